// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizes for the mult_ctrl shift-add multiplier.
// FSM state encoding, operand width and iteration count.
package mult_ctrl_pkg;

  localparam int MULT_W    = 16;
  localparam int MULT_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_ctrl_add16.sv
// add16: 16-bit adder; A+B+CI -> {CO,Sum}, plus block G/P.
// Ports: A, B, CI in; Sum, CO, G (generate), P (propagate) out.
module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic [15:0] Sum,
  output logic        CO,
  output logic        G,
  output logic        P
);

  logic [16:0] gsum;
  logic [16:0] full;

  assign gsum = {1'b0, A} + {1'b0, B};
  assign full = gsum + {16'b0, CI};

  assign Sum = full[15:0];
  assign CO  = full[16];
  assign G   = gsum[16];
  assign P   = &(A ^ B);

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: 16x16 unsigned shift-add multiplier, 16 cycles/op.
// Ports: clk, rst (sync, high), start, a, b in; busy, done, prod out;
// ovf out only when MULT_OVF_EN is defined (prod[31:16] != 0).
import mult_ctrl_pkg::*;

module mult_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
`ifdef MULT_OVF_EN
  output logic        ovf,
`endif
  output logic [31:0] prod
);

  state_e      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] q_q, q_d;
  logic [15:0] a_q, a_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] sum;
  logic        co;
  logic        unused_g;
  logic        unused_p;
  logic        c;
  logic [15:0] s;

  add16 u_add (
    .A   (a_q),
    .B   (m_q),
    .CI  (1'b0),
    .Sum (sum),
    .CO  (co),
    .G   (unused_g),
    .P   (unused_p)
  );

  // Add M only when the current multiplier bit is set.
  assign c = q_q[0] ? co  : 1'b0;
  assign s = q_q[0] ? sum : a_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        a_d   = {c, s[15:1]};
        q_d   = {s[0], q_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(MULT_ITER - 1))
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign prod = {a_q, q_q};

`ifdef MULT_OVF_EN
  assign ovf = (state_q != BUSY) & (|a_q);
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: directed corner cases + random ops.
// Expected products come from a plain a*b reference model.
module tb_mult_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] a = 0;
  logic [15:0] b = 0;
  logic        busy;
  logic        done;
  logic [31:0] prod;
  logic        ovf_w;

  mult_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef MULT_OVF_EN
    .ovf   (ovf_w),
`endif
    .prod  (prod)
  );

`ifndef MULT_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic        o;
    int          t;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   mon_en = 0;
  bit   abort_f = 0;
  int   run_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y,
                      input int t);
    exp_t e;
    e.p = {16'b0, x} * {16'b0, y};
`ifdef MULT_OVF_EN
    e.o = (e.p >> 16) != 0;
`else
    e.o = 1'b0;
`endif
    e.t = t;
    sbq.push_back(e);
  endtask

  // Monitor: pops on every done, tracks busy run lengths.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && done) chk("busy_done_excl", 1, 0);
      if (busy) begin
        run_len++;
      end else if (run_len != 0) begin
        if (abort_f) abort_f = 0;
        else chk("busy_len", run_len, 16);
        run_len = 0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("prod", prod, e.p);
          chk("ovf", {31'b0, ovf_w}, {31'b0, e.o});
          chk("done_cycle", cyc, e.t);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1;
    push(x, y, cyc + 17);
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] x, y;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_prod", prod, 0);
    chk("rst_ovf", {31'b0, ovf_w}, 0);
    rst = 0;
    mon_en = 1;

    issue(16'd3, 16'd5);
    drain();
    chk("idle_hold", prod, 32'h0000000F);

    issue(16'hFFFF, 16'hFFFF);
    drain();
    issue(16'h1234, 16'h0000);
    drain();
    issue(16'h0000, 16'hABCD);
    drain();

    // Start re-pulsed mid-operation must be ignored.
    issue(16'd7, 16'd9);
    repeat (3) @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    start = 1;
    @(negedge clk);
    start = 0;
    drain();

    // Reset during BUSY aborts with no done.
    @(negedge clk);
    a = 16'd100;
    b = 16'd200;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    abort_f = 1;
    rst = 1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_prod", prod, 0);
    chk("abort_ovf", {31'b0, ovf_w}, 0);
    rst = 0;
    repeat (25) @(negedge clk);

    // Start held through DONE: back-to-back with no IDLE gap.
    @(negedge clk);
    a = 16'h0100;
    b = 16'h0100;
    start = 1;
    push(16'h0100, 16'h0100, cyc + 17);
    push(16'h0100, 16'h0100, cyc + 34);
    repeat (18) @(negedge clk);
    start = 0;
    drain();

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 4))
        0: x = 16'hFFFF;
        1: x = 16'h0000;
        default: x = 16'($urandom);
      endcase
      y = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
      issue(x, y);
      drain();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
